// File: rtl/ace_ccu_conflict_tracker.sv
// Tracks in-flight cache-line indices per port in in-order FIFOs and stalls
// snoops whose line index matches any live entry.

module ace_ccu_conflict_tracker_lane #(
   parameter  int unsigned Depth       = 8,
   parameter  int unsigned CmAddrWidth = 8,
   localparam int unsigned CntW        = $clog2(Depth + 1)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   alloc_valid_i,
   input  logic [CmAddrWidth-1:0] alloc_addr_i,
   output logic                   alloc_ready_o,
   input  logic                   release_i,
   input  logic [CmAddrWidth-1:0] snoop_addr_i,
   output logic                   hit_o,
   output logic [CntW-1:0]        count_o,
   output logic                   rel_err_o
);

   localparam int unsigned PtrW = $clog2(Depth);

   typedef struct packed {
      logic                   vld;
      logic [CmAddrWidth-1:0] idx;
   } entry_t;

   entry_t [Depth-1:0] ent_q;
   logic [PtrW-1:0]    wptr_q, rptr_q;
   logic [CntW-1:0]    cnt_q;
   logic               alloc_fire, rel_fire;

   // Ready depends only on registered count: a release this cycle never frees a slot early.
   assign alloc_ready_o = (cnt_q != CntW'(Depth));
   assign alloc_fire    = alloc_valid_i & alloc_ready_o;
   assign rel_fire      = release_i & (cnt_q != '0);
   assign rel_err_o     = release_i & (cnt_q == '0);
   assign count_o       = cnt_q;

   always_comb begin
      hit_o = 1'b0;
      for (int i = 0; i < Depth; i++)
         if (ent_q[i].vld && (ent_q[i].idx == snoop_addr_i)) hit_o = 1'b1;
   end

   // Write and read slots never coincide when both fire: that needs empty
   // (no release) or full (no alloc).
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ent_q  <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (alloc_fire) begin
            ent_q[wptr_q].vld <= 1'b1;
            ent_q[wptr_q].idx <= alloc_addr_i;
            wptr_q            <= wptr_q + PtrW'(1);
         end
         if (rel_fire) begin
            ent_q[rptr_q].vld <= 1'b0;
            rptr_q            <= rptr_q + PtrW'(1);
         end
         cnt_q <= cnt_q + CntW'(alloc_fire) - CntW'(rel_fire);
      end
   end

endmodule

module ace_ccu_conflict_tracker #(
   parameter  int unsigned NoPorts     = 4,
   parameter  int unsigned Depth       = 8,
   parameter  int unsigned CmAddrWidth = 8,
   localparam int unsigned CntW        = $clog2(Depth + 1)
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic [NoPorts-1:0]                   alloc_valid_i,
   input  logic [NoPorts-1:0][CmAddrWidth-1:0]  alloc_addr_i,
   output logic [NoPorts-1:0]                   alloc_ready_o,
   input  logic [NoPorts-1:0]                   release_i,
   input  logic                                 snoop_valid_i,
   input  logic [CmAddrWidth-1:0]               snoop_addr_i,
   output logic                                 snoop_stall_o,
   output logic [NoPorts-1:0][CntW-1:0]         count_o,
   output logic                                 busy_o,
   output logic                                 err_o
);

   logic [NoPorts-1:0] hit, rel_err, nonempty;
   logic               err_q;

   for (genvar p = 0; p < NoPorts; p++) begin : g_lane
      ace_ccu_conflict_tracker_lane #(
         .Depth       (Depth),
         .CmAddrWidth (CmAddrWidth)
      ) u_lane (
         .clk_i         (clk_i),
         .rst_ni        (rst_ni),
         .alloc_valid_i (alloc_valid_i[p]),
         .alloc_addr_i  (alloc_addr_i[p]),
         .alloc_ready_o (alloc_ready_o[p]),
         .release_i     (release_i[p]),
         .snoop_addr_i  (snoop_addr_i),
         .hit_o         (hit[p]),
         .count_o       (count_o[p]),
         .rel_err_o     (rel_err[p])
      );
      assign nonempty[p] = (count_o[p] != '0);
   end

   assign snoop_stall_o = snoop_valid_i & (|hit);
   assign busy_o        = |nonempty;
   assign err_o         = err_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni)       err_q <= 1'b0;
      else if (|rel_err) err_q <= 1'b1;
   end

endmodule
